mux_n_pipe: RTL and testbench

- Parametrised N:1 data selector with a registered output stage and valid/ready flow control.
- Generalises the fixed 2- and 4-way selectors to any width and input count.
- A one-entry skid buffer gives full throughput under backpressure.
- Used between pipeline stages where the selected operand (forwarding, writeback source) must be registered and the stage may stall or flush.

---
 rtl/mux_n_pipe_pkg.sv | 20 ++
 rtl/mux_n_comb.sv | 43 ++++
 rtl/mux_n_pipe.sv | 140 ++++++++++++++
 tb/tb_mux_n_pipe.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mux_n_pipe_pkg.sv
// mux_n_pipe_pkg
//   Shared definitions for the N:1 registered selector family.
//   - DEF_WIDTH / DEF_NUM_IN : default data width and input count
//   - ST_*                   : occupancy encodings as {main valid, skid valid}
//   - sel_width()            : select-width helper (clog2, never below 1)
package mux_n_pipe_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 4;

  // Occupancy of the output stage, bit 1 = main valid, bit 0 = skid valid.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// mux_n_comb
//   Purely combinational N:1 selector. Any select value beyond the last
//   input picks the last input ("last input is default").
//   Ports:
//     in_data  [NUM_IN*WIDTH] flattened inputs, input k at [k*WIDTH +: WIDTH]
//     sel      [SEL_W]        input index
//     out_data [WIDTH]        selected input, unmodified
module mux_n_comb
  import mux_n_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

  logic [WIDTH-1:0] lanes_s [NUM_IN];
  logic [SEL_W-1:0] idx_s;

  genvar k;
  generate
    for (k = 0; k < NUM_IN; k++) begin : g_lane
      assign lanes_s[k] = in_data[k*WIDTH +: WIDTH];
    end
  endgenerate

  // Clamp out-of-range selects onto the last input.
  always_comb begin
    if (sel > LAST_IDX) begin
      idx_s = LAST_IDX;
    end else begin
      idx_s = sel;
    end
  end

  assign out_data = lanes_s[idx_s];

endmodule

// File: rtl/mux_n_pipe.sv
// mux_n_pipe
//   N:1 data selector with a registered output and valid/ready handshake.
//   A one-entry skid buffer keeps full throughput under backpressure, so
//   in_ready is a pure register and never depends on out_ready.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     in_data, sel          flattened inputs and index, taken on accept
//     in_valid / in_ready   upstream handshake (in_ready registered)
//     flush                 drops every held beat and the current input beat
//     out_data, out_sel     selected data and the sel it was chosen with
//     out_valid / out_ready downstream handshake
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] pick_data_s;

  logic             m_valid_r, s_valid_r, in_ready_r;
  logic [WIDTH-1:0] m_data_r, s_data_r;
  logic [SEL_W-1:0] m_sel_r, s_sel_r;

  logic             m_valid_s, s_valid_s;
  logic [WIDTH-1:0] m_data_s, s_data_s;
  logic [SEL_W-1:0] m_sel_s, s_sel_s;

  logic             accept_s, pop_s;

  mux_n_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (pick_data_s)
  );

  assign accept_s = in_valid && in_ready_r;
  assign pop_s    = m_valid_r && out_ready;

  // Next occupancy and data for the main/skid pair.
  always_comb begin
    m_valid_s = m_valid_r;
    s_valid_s = s_valid_r;
    m_data_s  = m_data_r;
    m_sel_s   = m_sel_r;
    s_data_s  = s_data_r;
    s_sel_s   = s_sel_r;
    if (flush) begin
      // Data registers keep stale contents; only the valid bits clear.
      m_valid_s = 1'b0;
      s_valid_s = 1'b0;
    end else begin
      case ({m_valid_r, s_valid_r})
        ST_EMPTY: begin
          if (accept_s) begin
            m_valid_s = 1'b1;
            m_data_s  = pick_data_s;
            m_sel_s   = sel;
          end else begin
            m_valid_s = 1'b0;
          end
        end
        ST_ONE: begin
          if (accept_s && pop_s) begin
            m_data_s = pick_data_s;
            m_sel_s  = sel;
          end else if (accept_s) begin
            // Main is stalled: park the new beat in the skid slot.
            s_valid_s = 1'b1;
            s_data_s  = pick_data_s;
            s_sel_s   = sel;
          end else if (pop_s) begin
            m_valid_s = 1'b0;
          end else begin
            m_valid_s = 1'b1;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop_s) begin
            m_data_s  = s_data_r;
            m_sel_s   = s_sel_r;
            s_valid_s = 1'b0;
          end else begin
            s_valid_s = 1'b1;
          end
        end
        default: begin
          // Skid valid without main valid cannot occur; recover to empty.
          m_valid_s = 1'b0;
          s_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State registers; in_ready is precomputed as "skid will be free".
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_r  <= 1'b0;
      s_valid_r  <= 1'b0;
      m_data_r   <= '0;
      m_sel_r    <= '0;
      s_data_r   <= '0;
      s_sel_r    <= '0;
      in_ready_r <= 1'b1;
    end else begin
      m_valid_r  <= m_valid_s;
      s_valid_r  <= s_valid_s;
      m_data_r   <= m_data_s;
      m_sel_r    <= m_sel_s;
      s_data_r   <= s_data_s;
      s_sel_r    <= s_sel_s;
      in_ready_r <= !s_valid_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = m_valid_r;
  assign out_data  = m_data_r;
  assign out_sel   = m_sel_r;

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe
//   Directed checks on a 32-bit 4-input instance and a randomized run on an
//   8-bit 5-input instance against a two-deep FIFO reference model.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=32, NUM_IN=4
  logic         a_reset, a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [127:0] a_in_data;
  logic [1:0]   a_sel, a_out_sel;
  logic [31:0]  a_out_data;

  // Instance B: WIDTH=8, NUM_IN=5
  logic         b_reset, b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [39:0]  b_in_data;
  logic [2:0]   b_sel, b_out_sel;
  logic [7:0]   b_out_data;

  mux_n_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut_a (
    .clk(clk), .reset(a_reset), .in_data(a_in_data), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
    .out_data(a_out_data), .out_sel(a_out_sel), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  mux_n_pipe #(.WIDTH(8), .NUM_IN(5)) u_dut_b (
    .clk(clk), .reset(b_reset), .in_data(b_in_data), .sel(b_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
    .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_a(input logic [31:0] v);
    a_in_data = {v, v, v, v};
  endtask

  // Reference model for B: ordered list of accepted {sel, data}, capacity 2.
  logic [10:0] q[$];
  logic [7:0]  lanes [5];
  logic [10:0] head, prev_head;
  logic [2:0]  idx;
  bit          hold, acc, pop;

  initial begin
    a_reset = 1'b1; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
    a_in_data = '0; a_sel = 2'd0;
    b_reset = 1'b1; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
    b_in_data = '0; b_sel = 3'd0;
    hold = 1'b0;
    tick();
    tick();
    check_val("rst_valid", a_out_valid, 1'b0);
    check_val("rst_data",  a_out_data,  32'h0);
    check_val("rst_sel",   a_out_sel,   2'd0);
    check_val("rst_ready", a_in_ready,  1'b1);
    check_val("rst_b_ready", b_in_ready, 1'b1);
    a_reset = 1'b0;
    b_reset = 1'b0;

    // Basic select, latency 1
    a_in_data = {32'h44, 32'h33, 32'h22, 32'h11};
    a_sel = 2'd2; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    check_val("sel2_data",  a_out_data,  32'h33);
    check_val("sel2_sel",   a_out_sel,   2'd2);
    check_val("sel2_valid", a_out_valid, 1'b1);
    check_val("sel2_ready", a_in_ready,  1'b1);
    a_in_valid = 1'b0;
    tick();
    check_val("drain_valid", a_out_valid, 1'b0);

    // Backpressure stream 1,2,3
    a_sel = 2'd0; set_a(32'h1); a_in_valid = 1'b1;
    tick();
    a_out_ready = 1'b0; set_a(32'h2);
    tick();
    set_a(32'h3);
    tick();
    check_val("bp_hold_data", a_out_data, 32'h1);
    check_val("bp_ready_low", a_in_ready, 1'b0);
    check_val("bp_valid",     a_out_valid, 1'b1);
    a_out_ready = 1'b1;
    tick();
    check_val("bp_out2",   a_out_data, 32'h2);
    check_val("bp_ready1", a_in_ready, 1'b1);
    tick();
    check_val("bp_out3",   a_out_data, 32'h3);
    check_val("bp_valid3", a_out_valid, 1'b1);
    a_in_valid = 1'b0;
    tick();
    check_val("bp_empty", a_out_valid, 1'b0);

    // Flush while FULL, with a beat presented in the flush cycle
    a_out_ready = 1'b0; a_in_valid = 1'b1; set_a(32'hA1);
    tick();
    set_a(32'hA2);
    tick();
    check_val("fl_full_ready", a_in_ready, 1'b0);
    check_val("fl_full_data",  a_out_data, 32'hA1);
    a_flush = 1'b1; set_a(32'hA3);
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    check_val("fl_valid", a_out_valid, 1'b0);
    check_val("fl_ready", a_in_ready,  1'b1);
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("fl_no_ghost", a_out_valid, 1'b0);
    end

    // Reset while FULL
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_sel = 2'd3; set_a(32'hB1);
    tick();
    set_a(32'hB2);
    tick();
    check_val("rf_sel",   a_out_sel,  2'd3);
    check_val("rf_ready", a_in_ready, 1'b0);
    a_reset = 1'b1; a_in_valid = 1'b0;
    tick();
    a_reset = 1'b0;
    check_val("rf_valid", a_out_valid, 1'b0);
    check_val("rf_data",  a_out_data,  32'h0);
    check_val("rf_osel",  a_out_sel,   2'd0);
    check_val("rf_iready", a_in_ready, 1'b1);

    // Out-of-range select on the 5-input instance
    b_in_data = {8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
    b_sel = 3'd6; b_in_valid = 1'b1; b_out_ready = 1'b1;
    tick();
    check_val("oor_data", b_out_data, 8'h0E);
    check_val("oor_sel",  b_out_sel,  3'd6);
    b_in_valid = 1'b0;
    tick();
    check_val("oor_empty", b_out_valid, 1'b0);

    // Randomized run against the FIFO model
    for (int c = 0; c < 10000; c++) begin
      check_val("rnd_valid", b_out_valid, (q.size() > 0) ? 1'b1 : 1'b0);
      check_val("rnd_ready", b_in_ready,  (q.size() < 2) ? 1'b1 : 1'b0);
      if (q.size() > 0) begin
        head = q[0];
        check_val("rnd_data", b_out_data, head[7:0]);
        check_val("rnd_sel",  b_out_sel,  head[10:8]);
        if (hold) begin
          check_val("rnd_stable", {b_out_sel, b_out_data}, prev_head);
        end
      end

      for (int k = 0; k < 5; k++) lanes[k] = 8'($urandom);
      b_in_data   = {lanes[4], lanes[3], lanes[2], lanes[1], lanes[0]};
      b_sel       = 3'($urandom_range(0, 7));
      b_in_valid  = ($urandom_range(0, 9) < 7);
      b_out_ready = ($urandom_range(0, 9) < 6);
      b_flush     = ($urandom_range(0, 49) == 0);

      hold = (q.size() > 0) && !b_out_ready && !b_flush;
      if (q.size() > 0) prev_head = q[0];

      if (b_flush) begin
        q.delete();
      end else begin
        acc = b_in_valid && (q.size() < 2);
        pop = b_out_ready && (q.size() > 0);
        if (pop) void'(q.pop_front());
        if (acc) begin
          idx = (b_sel >= 3'd5) ? 3'd4 : b_sel;
          q.push_back({b_sel, lanes[idx]});
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
